usr_shift_sequencer: RTL

- Command-driven controller for the combinational 8-bit universal shift datapath (`a`, `s`, `p`; mode 00 = shift left, 01 = hold, 10 = shift right, 11 = parallel load).
- Owns the working register and feeds it back through the datapath one step per cycle. This turns a single-step shifter into multi-step load/shift operations.
- Uses a valid/ready command port in and a valid/ready response port out. Sits between a register-bus or CPU front end and the shift datapath.

---
 rtl/usr_shift_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer
//   Command-driven controller wrapped around a combinational universal shift
//   datapath (a, s, p; s: 00 left, 01 hold, 10 right, 11 parallel load).
//   Owns the working register data_q and feeds it back through the datapath
//   one step per cycle, which turns a single-step shifter into multi-step
//   load/shift/hold operations.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_op               00 left, 01 hold, 10 right, 11 load
//   cmd_data             load value (ignored for hold)
//   cmd_count            shift/hold steps, clamped to WIDTH (ignored for load)
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             result word (= data_q)
//   busy                 high in every state except IDLE
//   usr_a, usr_s         operand and mode to the datapath
//   usr_p                datapath result
//
// Optional build macro USR_SHIFT_SEQ_SERIAL_EN adds:
//   serial_out           bit leaving the register on each left/right step
//   serial_valid         high while a left/right step is in progress
module usr_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [WIDTH-1:0] usr_a,
  output logic [1:0]       usr_s,
  input  logic [WIDTH-1:0] usr_p
`ifdef USR_SHIFT_SEQ_SERIAL_EN
  ,
  output logic             serial_out,
  output logic             serial_valid
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_LEFT  = 2'b00;
  localparam logic [1:0] OP_HOLD  = 2'b01;
  localparam logic [1:0] OP_RIGHT = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_ld;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_clamp;
  logic             accept;

  // More than WIDTH steps cannot change the result further, so clamp.
  assign cnt_clamp = (cmd_count > CNT_MAX) ? CNT_MAX : cmd_count;
  assign accept    = cmd_valid && (state_q == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Hold skips LOAD so the previous result is preserved.
          if (cmd_op == OP_HOLD) state_d = (cnt_clamp != '0) ? SHIFT : DONE;
          else                   state_d = LOAD;
        end
      end
      LOAD: begin
        if (op_q == OP_LOAD) state_d = DONE;
        else                 state_d = (cnt_q != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt_q <= CNT_ONE) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working register, command latches and step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      data_ld <= '0;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= cmd_op;
            data_ld <= cmd_data;
            cnt_q   <= cnt_clamp;
          end
        end
        LOAD: data_q <= usr_p;
        SHIFT: begin
          // Fill bits come from the datapath; nothing is substituted here.
          data_q <= usr_p;
          cnt_q  <= cnt_q - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Output logic: everything is decoded from registered state only.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == DONE);
    rsp_data  = data_q;
    usr_s     = OP_HOLD;
    usr_a     = data_q;
    case (state_q)
      LOAD: begin
        usr_s = OP_LOAD;
        usr_a = data_ld;
      end
      SHIFT: begin
        usr_s = op_q;
        usr_a = data_q;
      end
      default: ;
    endcase
  end

`ifdef USR_SHIFT_SEQ_SERIAL_EN
  always_comb begin
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    if (state_q == SHIFT) begin
      if (op_q == OP_LEFT) begin
        serial_valid = 1'b1;
        serial_out   = data_q[WIDTH-1];
      end else if (op_q == OP_RIGHT) begin
        serial_valid = 1'b1;
        serial_out   = data_q[0];
      end
    end
  end
`endif

endmodule
